// File: rtl/rf_window_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_seq_pkg
//  Description : Shared types and elaboration helpers for the receptive-field
//                window sequencer (state enum, output-geometry arithmetic,
//                pixel addressing). Honours RF_ZERO_PAD_EN for padding.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of the row/column tags carried on the output stream.
   localparam int c_TAG_W = 8;

`ifdef RF_ZERO_PAD_EN
   localparam bit c_PAD_EN = 1'b1;
`else
   localparam bit c_PAD_EN = 1'b0;
`endif

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // "Same" padding when enabled, valid-only convolution otherwise.
   function automatic int pad_of(input int f);
      return c_PAD_EN ? (f - 1) / 2 : 0;
   endfunction

   // Output extent along one axis; a stride below one is treated as one so
   // that the elaboration check can report it instead of a divide by zero.
   function automatic int out_dim(input int n, input int f, input int s, input int pad);
      int s_safe;
      s_safe = (s < 1) ? 1 : s;
      return (n + 2 * pad - f) / s_safe + 1;
   endfunction

   // Pixel index of (channel, row, column) in the flattened image.
   function automatic int pix_offset(input int k, input int r, input int c,
                                     input int h, input int w);
      return (k * h + r) * w + c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rf_window_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_window_sequencer_if
//  Description : Valid/ready stream carrying receptive-field beats from the
//                window sequencer to the convolution core.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rf_window_sequencer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int D          = 1,
   parameter int F          = 3,
   parameter int P          = 3
);
   logic                            rf_valid;
   logic                            rf_ready;
   logic [P*D*F*F*DATA_WIDTH-1:0]   rf_data;
   logic [7:0]                      rf_row;
   logic [7:0]                      rf_col;
   logic [P-1:0]                    rf_mask;
   logic                            rf_last;

   modport master (
      output rf_valid, rf_data, rf_row, rf_col, rf_mask, rf_last,
      input  rf_ready
   );

   modport slave (
      input  rf_valid, rf_data, rf_row, rf_col, rf_mask, rf_last,
      output rf_ready
   );
endinterface
`default_nettype wire

// File: rtl/rf_window_sequencer_lane_extract.sv
`default_nettype none
// ============================================================================
//  Module      : rf_lane_extract
//  Description : Combinational extraction of one lane's D*F*F window from a
//                flattened image. Lanes beyond the output width are masked
//                and zeroed. With RF_ZERO_PAD_EN, taps outside the image
//                read as zero; without it no bounds logic is built.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_lane_extract
   import rf_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int D          = 1,
   parameter int H          = 8,
   parameter int W          = 8,
   parameter int F          = 3,
   parameter int S          = 1,
   parameter int PAD        = 0,
   parameter int OW         = 6
) (
   input  wire logic [D*H*W*DATA_WIDTH-1:0] image_i,
   input  wire logic [7:0]                  row_i,
   input  wire logic [15:0]                 col_i,
   output logic      [D*F*F*DATA_WIDTH-1:0] lane_o,
   output logic                             valid_o
);
   localparam int c_NPIX   = D * H * W;
   localparam int c_IMG_W  = c_NPIX * DATA_WIDTH;
   localparam int c_LANE_W = D * F * F * DATA_WIDTH;
   localparam int c_IDX_W  = (c_NPIX > 1) ? $clog2(c_NPIX) : 1;

   logic [DATA_WIDTH-1:0] w_pix [c_NPIX];
   logic signed [31:0]    w_y0;
   logic signed [31:0]    w_x0;

   // Pixel 0 occupies the most-significant slot of the flat image bus.
   for (genvar gi = 0; gi < c_NPIX; gi++) begin : g_unpack
      assign w_pix[gi] = image_i[c_IMG_W-1-gi*DATA_WIDTH -: DATA_WIDTH];
   end

   // Window origin in input coordinates (may be negative when padding).
   assign w_y0    = int'(row_i) * S - PAD;
   assign w_x0    = int'(col_i) * S - PAD;
   assign valid_o = (col_i < 16'(OW));

   for (genvar k = 0; k < D; k++) begin : g_ch
      for (genvar i = 0; i < F; i++) begin : g_frow
         for (genvar j = 0; j < F; j++) begin : g_fcol
            localparam int c_TAP = (k * F + i) * F + j;
            logic signed [31:0]    w_r;
            logic signed [31:0]    w_c;
            logic [DATA_WIDTH-1:0] w_px;

            // Fetch one tap; gated to zero for masked lanes or padding.
            always_comb begin
               w_r  = w_y0 + i;
               w_c  = w_x0 + j;
               w_px = '0;
               if (valid_o) begin
`ifdef RF_ZERO_PAD_EN
                  if ((w_r >= 0) && (w_r < H) && (w_c >= 0) && (w_c < W)) begin
                     w_px = w_pix[c_IDX_W'(pix_offset(k, w_r, w_c, H, W))];
                  end
`else
                  w_px = w_pix[c_IDX_W'(pix_offset(k, w_r, w_c, H, W))];
`endif
               end
            end

            assign lane_o[c_LANE_W-1-c_TAP*DATA_WIDTH -: DATA_WIDTH] = w_px;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/rf_window_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rf_window_sequencer
//  Description : Latches a D x H x W image on start and streams every output
//                row / column group as P receptive fields per beat on a
//                valid/ready interface. Optional macro RF_ZERO_PAD_EN selects
//                "same" zero padding instead of valid-only windows.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_window_sequencer
   import rf_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int D          = 1,
   parameter int H          = 8,
   parameter int W          = 8,
   parameter int F          = 3,
   parameter int S          = 1,
   parameter int P          = 3
) (
   input  wire logic                        clk,
   input  wire logic                        reset_n,
   input  wire logic                        start,
   input  wire logic [D*H*W*DATA_WIDTH-1:0] image,
   output logic                             busy,
   output logic                             done,
   rf_window_sequencer_if.master            rf
);
   localparam int c_PAD    = pad_of(F);
   localparam int c_OW     = out_dim(W, F, S, c_PAD);
   localparam int c_OH     = out_dim(H, F, S, c_PAD);
   localparam int c_G      = ceil_div(c_OW, (P < 1) ? 1 : P);
   localparam int c_IMG_W  = D * H * W * DATA_WIDTH;
   localparam int c_LANE_W = D * F * F * DATA_WIDTH;
   localparam int c_BEAT_W = P * c_LANE_W;

   if (S < 1) begin : g_chk_stride
      $error("rf_window_sequencer: S must be at least 1");
   end
   if (P < 1) begin : g_chk_lanes
      $error("rf_window_sequencer: P must be at least 1");
   end
   if ((F > H) || (F > W)) begin : g_chk_filter
      $error("rf_window_sequencer: filter larger than image");
   end
   if ((c_OH > 255) || (c_OW > 255)) begin : g_chk_tags
      $error("rf_window_sequencer: output extent exceeds 8-bit tags");
   end

   state_t                 state_q, state_d;
   logic [c_IMG_W-1:0]     img_q;
   logic [c_TAG_W-1:0]     row_q, row_d;
   logic [c_TAG_W-1:0]     grp_q, grp_d;
   logic                   load;
   logic [c_BEAT_W-1:0]    data_q;
   logic [c_TAG_W-1:0]     col_q;
   logic [P-1:0]           mask_q;
   logic                   last_q;

   logic [c_IMG_W-1:0]     w_src;
   logic [c_BEAT_W-1:0]    w_beat;
   logic [P-1:0]           w_mask;

   // State register; reset aborts any sequence without a done pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and beat advance; load registers the next beat's window.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      row_d   = row_q;
      grp_d   = grp_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               load    = 1'b1;
               row_d   = '0;
               grp_d   = '0;
            end
         end
         RUN: begin
            if (rf.rf_ready) begin
               if (last_q) begin
                  state_d = DONE;
               end else begin
                  load = 1'b1;
                  if (grp_q == c_TAG_W'(c_G - 1)) begin
                     grp_d = '0;
                     row_d = row_q + 1'b1;
                  end else begin
                     grp_d = grp_q + 1'b1;
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Beat 0 is built from the live image so it is ready one cycle after start.
   assign w_src = (state_q == IDLE) ? image : img_q;

   for (genvar p = 0; p < P; p++) begin : g_lane
      logic [15:0] w_col;
      assign w_col = 16'(int'(grp_d) * P + p);

      rf_lane_extract #(
         .DATA_WIDTH (DATA_WIDTH),
         .D          (D),
         .H          (H),
         .W          (W),
         .F          (F),
         .S          (S),
         .PAD        (c_PAD),
         .OW         (c_OW)
      ) u_lane (
         .image_i (w_src),
         .row_i   (row_d),
         .col_i   (w_col),
         .lane_o  (w_beat[c_BEAT_W-1-p*c_LANE_W -: c_LANE_W]),
         .valid_o (w_mask[p])
      );
   end

   // Image latch, beat counters and output registers; held during stalls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         img_q  <= '0;
         row_q  <= '0;
         grp_q  <= '0;
         data_q <= '0;
         col_q  <= '0;
         mask_q <= '0;
         last_q <= 1'b0;
      end else begin
         if ((state_q == IDLE) && start) begin
            img_q <= image;
         end
         if (load) begin
            row_q  <= row_d;
            grp_q  <= grp_d;
            data_q <= w_beat;
            col_q  <= c_TAG_W'(int'(grp_d) * P);
            mask_q <= w_mask;
            last_q <= (row_d == c_TAG_W'(c_OH - 1)) && (grp_d == c_TAG_W'(c_G - 1));
         end else if ((state_q == RUN) && rf.rf_ready) begin
            last_q <= 1'b0;
         end
      end
   end

   assign busy        = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign rf.rf_valid = (state_q == RUN);
   assign rf.rf_data  = data_q;
   assign rf.rf_row   = row_q;
   assign rf.rf_col   = col_q;
   assign rf.rf_mask  = mask_q;
   assign rf.rf_last  = last_q;

endmodule
`default_nettype wire

// File: doc/rf_window_sequencer.md
Name: rf_window_sequencer

Overview:
- Sequential successor to the combinational receptive-field selector.
- Latches a full D×H×W image on start, then walks every output row and column group.
- Emits P receptive fields per beat on a valid/ready stream to the convolution core, with configurable stride and explicit row/column tags, lane mask and last-beat flag.
- Sits between the image buffer and the MAC array; replaces fixed two-half column selection.

Parameters:
- DATA_WIDTH, 8, bits per pixel
- D, 1, channel count (filter depth)
- H, 8, image height
- W, 8, image width
- F, 3, filter size (F×F)
- S, 1, stride (both axes), ≥1
- P, 3, receptive fields (lanes) per output beat, ≥1

Ports:
- clk, input, 1, rising-edge clock
- reset_n, input, 1, asynchronous active-low reset
- start, input, 1, pulse: latch image, begin sequence (IDLE only)
- image, input, D*H*W*DATA_WIDTH, flattened [0:N-1]; pixel (k,r,c) at offset ((k*H+r)*W+c)*DATA_WIDTH
- busy, output, 1, high from accepted start until done
- done, output, 1, one-cycle pulse after final beat accepted
- rf_valid, output, 1, beat available
- rf_ready, input, 1, consumer accepts beat
- rf_data, output, P*D*F*F*DATA_WIDTH, [0:M-1]; lane p, channel k, filter row i, F contiguous pixels left→right
- rf_row, output, 8, output row index of beat
- rf_col, output, 8, output column index of lane 0
- rf_mask, output, P, bit p set = lane p valid
- rf_last, output, 1, final beat of image

Behaviour:
- Derived values:
  - PAD = 0 (see optional feature).
  - OW = (W+2*PAD-F)/S+1 and OH = (H+2*PAD-F)/S+1.
  - G = ceil(OW/P) column groups per row; total beats = OH*G.
- Lane window position: lane p of group g, row y covers output column x = g*P+p, input origin (y*S-PAD, x*S-PAD).
- Reset (async, reset_n low):
  - FSM to IDLE.
  - busy, done, rf_valid, rf_last = 0.
  - rf_data, rf_row, rf_col, rf_mask = 0.
  - Latched image cleared.
- FSM IDLE:
  - start=1 → latch image, row=0, grp=0, go to RUN.
  - busy=1 and rf_valid=1 on the next cycle with beat 0 registered (latency 1).
- FSM RUN: rf_valid held high. On rf_valid&&rf_ready:
  - If not last: advance grp (wrap to 0 → row+1) and present the next beat registered on the following cycle. Back-to-back acceptance gives 1 beat/cycle.
  - If last: go to DONE, rf_valid=0.
- FSM DONE: done=1 for one cycle, busy=0, then IDLE. start in DONE is ignored.
- Backpressure: while rf_valid&&!rf_ready, every rf_* output stays stable.
- start while busy is ignored. The latched image does not change mid-sequence.
- Partial last group: lanes with x ≥ OW have their rf_mask bit cleared and their data forced to zero.
- rf_last=1 exactly on beat (OH-1, G-1).
- rf_row/rf_col widths are truncated; elaboration must fail ($error) if OH or OW > 255, S<1, P<1, or F>H or F>W.
- Reset mid-RUN: immediate abort with no done pulse. The next start restarts from beat 0.

Optional Feature:
- Macro: RF_ZERO_PAD_EN
- Defined:
  - PAD = (F-1)/2.
  - Taps falling outside 0..H-1 / 0..W-1 read as zero.
  - With S=1 and odd F, OH=H and OW=W.
- Undefined:
  - PAD = 0, valid-only convolution.
  - No bounds logic synthesised.

Decomposition:
- Package rf_seq_pkg:
  - ceil-div function.
  - Localparam helpers for OW/OH/G/PAD.
  - FSM state enum (IDLE, RUN, DONE).
  - Pixel-offset function.
- Sub-module rf_lane_extract: combinational extraction of one lane's D*F*F window (with pad/zero and mask gating) from the latched image. Instantiated P times via generate. The top holds the FSM, counters and output registers.

Test Plan:
- Defaults, image pixel (0,r,c)=8r+c, ready always 1 → 12 beats:
  - Beat 0: rf_row=0, rf_col=0, mask=3'b111; lane0 bytes 0,1,2,8,9,10,16,17,18.
  - Beat 1: rf_col=3, lane2 bytes 5,6,7,13,14,15,21,22,23.
  - rf_last on beat 11; done pulse one cycle later.
- P=4 → G=2:
  - Beat 1: rf_col=4, mask=4'b0011; lanes 2,3 data all zero.
- S=2 → OW=OH=3, 3 beats:
  - Beat 1 (row 1): lane0 origin (2,0), bytes 16,17,18,24,25,26,32,33,34.
- Backpressure: rf_ready low 3 cycles on beat 4 → rf_data/row/col/mask unchanged; beat 5 appears the cycle after the handshake.
- start pulsed at beat 6 with a different image → ignored; sequence and data unchanged. reset_n low at beat 7 → all outputs 0 asynchronously, no done; new start gives beat 0.
- RF_ZERO_PAD_EN defined, defaults → 8×8 outputs, 24 beats:
  - Beat 0: lane0 bytes 0,0,0,0,0,1,0,8,9 (pixel 0 = 0; padding positions = 0).
